// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared types, ALUMODE codes and mux select encodings for dsp_alu48
package dsp_pkg;

  typedef logic [47:0] dsp_word_t;

  // Logic codes are named for their Y=00 meaning; Y=10 swaps in the OR/XNOR family.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_NZADD = 4'b0001;
  localparam logic [3:0] ALU_NSUM  = 4'b0010;
  localparam logic [3:0] ALU_ZSUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_XNOR  = 4'b0101;
  localparam logic [3:0] ALU_XNOR2 = 4'b0110;
  localparam logic [3:0] ALU_XOR2  = 4'b0111;
  localparam logic [3:0] ALU_AND   = 4'b1100;
  localparam logic [3:0] ALU_ANDN  = 4'b1101;
  localparam logic [3:0] ALU_NAND  = 4'b1110;
  localparam logic [3:0] ALU_NOTOR = 4'b1111;

  localparam int P_SHIFT = 17;

  typedef enum logic [1:0] {X_ZERO = 2'b00, X_M = 2'b01, X_P = 2'b10, X_AB = 2'b11} x_sel_e;
  typedef enum logic [1:0] {Y_ZERO = 2'b00, Y_MZERO = 2'b01, Y_ONES = 2'b10, Y_C = 2'b11} y_sel_e;
  typedef enum logic [2:0] {
    Z_ZERO     = 3'b000,
    Z_PCIN     = 3'b001,
    Z_P        = 3'b010,
    Z_C        = 3'b011,
    Z_P_ALT    = 3'b100,
    Z_PCIN_SHR = 3'b101,
    Z_P_SHR    = 3'b110,
    Z_RSVD     = 3'b111
  } z_sel_e;
  typedef enum logic [1:0] {W_ZERO = 2'b00, W_P = 2'b01, W_RND = 2'b10, W_C = 2'b11} w_sel_e;

endpackage

// File: rtl/dsp_alu48_core.sv
// rtl/dsp_alu48_core.sv - combinational X/Y/Z/W input muxes and 48-bit arithmetic/logic unit
module dsp_alu48_core
  import dsp_pkg::*;
#(
  parameter dsp_word_t RND = 48'h0
) (
  input  logic [47:0] i_ab,
  input  logic [47:0] i_m,
  input  logic [47:0] i_c,
  input  logic [47:0] i_p,
  input  logic        i_carryin,
  input  logic [3:0]  i_alumode,
  input  logic [8:0]  i_opmode,
  output logic [47:0] o_result,
  output logic        o_carryout
);

  x_sel_e    w_xs;
  y_sel_e    w_ys;
  z_sel_e    w_zs;
  w_sel_e    w_ws;
  dsp_word_t w_x, w_y, w_z, w_w, w_lg;
  logic [48:0] w_s, w_zx, w_r;

  assign w_xs = x_sel_e'(i_opmode[1:0]);
  assign w_ys = y_sel_e'(i_opmode[3:2]);
  assign w_zs = z_sel_e'(i_opmode[6:4]);
  assign w_ws = w_sel_e'(i_opmode[8:7]);

  always_comb begin
    w_x = '0;
    case (w_xs)
      X_M:     w_x = i_m;
      X_P:     w_x = i_p;
      X_AB:    w_x = i_ab;
      default: w_x = '0;
    endcase
    w_y = '0;
    case (w_ys)
      Y_ONES:  w_y = '1;
      Y_C:     w_y = i_c;
      default: w_y = '0;
    endcase
    w_z = '0;
    case (w_zs)
      Z_P, Z_P_ALT: w_z = i_p;
      Z_C:          w_z = i_c;
      Z_P_SHR:      w_z = dsp_word_t'($signed(i_p) >>> P_SHIFT);
      default:      w_z = '0;
    endcase
    w_w = '0;
    case (w_ws)
      W_P:     w_w = i_p;
      W_RND:   w_w = RND;
      W_C:     w_w = i_c;
      default: w_w = '0;
    endcase
  end

  assign w_s  = {1'b0, w_w} + {1'b0, w_x} + {1'b0, w_y} + {48'b0, i_carryin};
  assign w_zx = {1'b0, w_z};

  always_comb begin
    w_lg = '0;
    if (w_ys == Y_ZERO) begin
      case (i_alumode)
        ALU_XOR, ALU_XOR2:   w_lg = w_x ^ w_z;
        ALU_XNOR, ALU_XNOR2: w_lg = ~(w_x ^ w_z);
        ALU_AND:             w_lg = w_x & w_z;
        ALU_ANDN:            w_lg = w_x & ~w_z;
        ALU_NAND:            w_lg = ~(w_x & w_z);
        ALU_NOTOR:           w_lg = ~w_x | w_z;
        default:             w_lg = '0;
      endcase
    end else if (w_ys == Y_ONES) begin
      case (i_alumode)
        ALU_XOR, ALU_XOR2:   w_lg = ~(w_x ^ w_z);
        ALU_XNOR, ALU_XNOR2: w_lg = w_x ^ w_z;
        ALU_AND:             w_lg = w_x | w_z;
        ALU_ANDN:            w_lg = w_x | ~w_z;
        ALU_NAND:            w_lg = ~(w_x | w_z);
        ALU_NOTOR:           w_lg = ~w_x & w_z;
        default:             w_lg = '0;
      endcase
    end
  end

  // Bit 48 of every arithmetic form is the carry/borrow out.
  always_comb begin
    w_r = '0;
    case (i_alumode)
      ALU_ADD:   w_r = w_zx + w_s;
      ALU_ZSUB:  w_r = w_zx - w_s;
      ALU_NZADD: w_r = w_s + ~w_zx;
      ALU_NSUM:  w_r = ~(w_zx + w_s);
      default:   w_r = {1'b0, w_lg};
    endcase
  end

  assign o_result   = w_r[47:0];
  assign o_carryout = w_r[48];

endmodule

// File: rtl/dsp_alu48.sv
// rtl/dsp_alu48.sv - 48-bit DSP slice: optional 27x18 multiplier (DSP_MULT_EN), ALU core, optional P register
module dsp_alu48
  import dsp_pkg::*;
#(
  parameter int        PREG = 0,
  parameter dsp_word_t RND  = 48'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic        carryin,
  input  logic [3:0]  alumode,
  input  logic [8:0]  opmode,
  input  logic        ce_p,
  output logic [47:0] p,
  output logic        carryout
);

  dsp_word_t w_m, w_p_fb, w_res;
  logic      w_co;

`ifdef DSP_MULT_EN
  logic [44:0] w_a_ext, w_b_ext, w_prod;
  assign w_a_ext = {{18{a[26]}}, a[26:0]};
  assign w_b_ext = {{27{b[17]}}, b};
  assign w_prod  = 45'($signed(w_a_ext) * $signed(w_b_ext));
  assign w_m     = {{3{w_prod[44]}}, w_prod};
`else
  assign w_m = '0;
`endif

  dsp_alu48_core #(.RND(RND)) u_core (
    .i_ab       ({a, b}),
    .i_m        (w_m),
    .i_c        (c),
    .i_p        (w_p_fb),
    .i_carryin  (carryin),
    .i_alumode  (alumode),
    .i_opmode   (opmode),
    .o_result   (w_res),
    .o_carryout (w_co)
  );

  generate
    if (PREG == 1) begin : g_preg
      dsp_word_t r_p;
      logic      r_co;
      always_ff @(posedge clock) begin
        if (!reset) begin
          r_p  <= '0;
          r_co <= 1'b0;
        end else if (ce_p) begin
          r_p  <= w_res;
          r_co <= w_co;
        end
      end
      assign p        = r_p;
      assign carryout = r_co;
      assign w_p_fb   = r_p;
    end else if (PREG == 0) begin : g_comb
      // No P register: feedback selects read zero and the clock side is idle.
      logic w_unused;
      assign w_unused = &{1'b0, clock, reset, ce_p};
      assign p        = w_res;
      assign carryout = w_co;
      assign w_p_fb   = '0;
    end else begin : g_bad_preg
      $fatal(1, "dsp_alu48: PREG must be 0 or 1");
    end
  endgenerate

endmodule

// File: tb/tb_dsp_alu48.sv
// tb/tb_dsp_alu48.sv - directed self-checking bench for dsp_alu48 (PREG=0 and PREG=1 instances)
module tb_dsp_alu48;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic        carryin;
  logic [3:0]  alumode;
  logic [8:0]  opmode;
  logic        ce_p;
  logic [47:0] p0, p1;
  logic        co0, co1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  dsp_alu48 #(.PREG(0)) u_dut0 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin),
    .alumode(alumode), .opmode(opmode), .ce_p(ce_p), .p(p0), .carryout(co0)
  );

  dsp_alu48 #(.PREG(1)) u_dut1 (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin),
    .alumode(alumode), .opmode(opmode), .ce_p(ce_p), .p(p1), .carryout(co1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_ab(input logic [47:0] v);
    {a, b} = v;
  endtask

  task automatic comb_vec(input string tag, input logic [3:0] am, input logic [8:0] om,
                          input logic [47:0] ab, input logic [47:0] cv, input logic ci,
                          input logic [47:0] exp_p, input logic exp_co);
    @(negedge clock);
    alumode = am; opmode = om; set_ab(ab); c = cv; carryin = ci;
    #1;
    check({tag, "_p"}, 64'(p0), 64'(exp_p));
    check({tag, "_co"}, 64'(co0), 64'(exp_co));
  endtask

  task automatic seq_step(input string tag, input logic [47:0] exp_p, input logic exp_co);
    @(posedge clock);
    #1;
    check({tag, "_p"}, 64'(p1), 64'(exp_p));
    check({tag, "_co"}, 64'(co1), 64'(exp_co));
  endtask

  initial begin
    reset = 1'b0; ce_p = 1'b1; carryin = 1'b0; c = 48'd0;
    alumode = 4'b0000; opmode = 9'b000100011; set_ab(48'd5);
    seq_step("rst0", 48'd0, 1'b0);
    seq_step("rst1", 48'd0, 1'b0);

    // Combinational vectors on the PREG=0 instance, run while reset is held low.
    comb_vec("and",   4'b1100, 9'b000110011, 48'h0000_FFFF_00F0, 48'h0000_0F0F_0FF0, 1'b0, 48'h0000_0F0F_00F0, 1'b0);
    comb_vec("or_y2", 4'b1100, 9'b000111011, 48'h0000_FFFF_00F0, 48'h0000_0F0F_0FF0, 1'b0, 48'h0000_FFFF_0FF0, 1'b0);
    comb_vec("xor",   4'b0100, 9'b000110011, 48'h0000_FFFF_00F0, 48'h0000_0F0F_0FF0, 1'b1, 48'h0000_F0F0_0F00, 1'b0);
    comb_vec("bad_y", 4'b1100, 9'b000111111, 48'h0000_FFFF_00F0, 48'h0000_0F0F_0FF0, 1'b0, 48'h0, 1'b0);
    comb_vec("addc",  4'b0000, 9'b000110011, 48'hFFFF_FFFF_FFFF, 48'd1,   1'b0, 48'h0, 1'b1);
    comb_vec("addci", 4'b0000, 9'b000110011, 48'd10,             48'd5,   1'b1, 48'd16, 1'b0);
    comb_vec("sub",   4'b0011, 9'b000110011, 48'd30,             48'd100, 1'b0, 48'd70, 1'b0);
    comb_vec("subbw", 4'b0011, 9'b000110011, 48'd100,            48'd30,  1'b0, 48'hFFFF_FFFF_FFBA, 1'b1);
    comb_vec("nzadd", 4'b0001, 9'b000110011, 48'd10,             48'd3,   1'b0, 48'd6, 1'b0);
    comb_vec("nsum",  4'b0010, 9'b000110011, 48'd3,              48'd5,   1'b0, 48'hFFFF_FFFF_FFF7, 1'b1);
    comb_vec("w_c",   4'b0000, 9'b110000011, 48'h23,             48'h100, 1'b0, 48'h123, 1'b0);
    comb_vec("ones",  4'b0000, 9'b000001000, 48'd0,              48'd0,   1'b0, 48'hFFFF_FFFF_FFFF, 1'b0);
    comb_vec("onesc", 4'b0000, 9'b000001000, 48'd0,              48'd0,   1'b1, 48'h0, 1'b1);
    comb_vec("pfb0",  4'b0000, 9'b000100010, 48'd7,              48'd9,   1'b0, 48'h0, 1'b0);

    @(negedge clock);
    alumode = 4'b0000; opmode = 9'b000000001; c = 48'd0; carryin = 1'b0;
    a = 30'h3FFF_FFFD; b = 18'd7;
    #1;
`ifdef DSP_MULT_EN
    check("mul_p", 64'(p0), 64'(48'hFFFF_FFFF_FFEB));
`else
    check("mul_p", 64'(p0), 64'(48'h0));
`endif
    check("mul_co", 64'(co0), 64'(1'b0));
    check("rst_hold", 64'(p1), 64'(48'h0));

    // Accumulate on the PREG=1 instance.
    @(negedge clock);
    alumode = 4'b0000; opmode = 9'b000100011; set_ab(48'd5); c = 48'd0; carryin = 1'b0;
    reset = 1'b1; ce_p = 1'b1;
    seq_step("acc1", 48'd5, 1'b0);
    check("acc_nofb", 64'(p0), 64'(48'd5));
    seq_step("acc2", 48'd10, 1'b0);
    seq_step("acc3", 48'd15, 1'b0);
    seq_step("acc4", 48'd20, 1'b0);
    @(negedge clock); ce_p = 1'b0;
    seq_step("hold1", 48'd20, 1'b0);
    seq_step("hold2", 48'd20, 1'b0);

    @(negedge clock); ce_p = 1'b1; reset = 1'b0;
    seq_step("midrst", 48'd0, 1'b0);
    @(negedge clock); reset = 1'b1;
    seq_step("restart", 48'd5, 1'b0);
    seq_step("restart2", 48'd10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dsp_alu48.md
Name: dsp_alu48

Overview:
- Behavioural, synthesizable model of a single 48-bit DSP slice: ALU datapath, OPMODE input muxes, optional multiplier, optional P output register.
- Stands in for the vendor DSP primitive in simulation and portable builds.
- Wrapped by the dsp_* operator blocks (and, or, add, sub, mul), which drive fixed ALUMODE/OPMODE values.

Parameters:
- PREG, 0, P output pipeline stages (0 = combinational P, 1 = registered P); other values rejected at elaboration.
- RND, 48'h0, constant selected by W mux code 10.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- a  in  30  A data; A:B concatenation uses all 30 bits; multiplier uses a[26:0] signed.
- b  in  18  B data; multiplier operand, signed.
- c  in  48  C data.
- carryin  in  1  ALU carry-in.
- alumode  in  4  ALU operation select.
- opmode  in  9  [1:0]=X, [3:2]=Y, [6:4]=Z, [8:7]=W mux selects.
- ce_p  in  1  clock enable for P register (ignored when PREG=0).
- p  out  48  result.
- carryout  out  1  ALU carry/borrow out.

Behaviour:
- AB = {a,b} (48 bits). M = sign-extended 45-bit product a[26:0]*b.
- X mux: 00 → 0; 01 → M; 10 → P register value; 11 → AB.
- Y mux: 00 → 0; 01 → 0 (product is carried entirely on X); 10 → all ones; 11 → C.
- Z mux: 000 → 0; 001/101 → 0 (no cascade input); 010 and 100 → P; 011 → C; 110 → P>>>17 (arithmetic); 111 → 0.
- W mux: 00 → 0; 01 → P; 10 → RND; 11 → C.
- Codes X=10, Z=010/100/110 and W=01 feed back the P register value; with PREG=0 they read 0.
- Arithmetic ALUMODE; S = W+X+Y+carryin is computed at 49 bits, and carryout = bit 48 of the 49-bit result:
  - 0000: Z+S.
  - 0011: Z−S.
  - 0001: −Z+S−1.
  - 0010: −(Z+S)−1 (bitwise NOT of Z+S).
- Logic ALUMODE with Y=00 (W, Y, carryin ignored; carryout=0):
  - 0100/0111: X^Z.
  - 0101/0110: ~(X^Z).
  - 1100: X&Z.
  - 1101: X&~Z.
  - 1110: ~(X&Z).
  - 1111: ~X|Z.
- Logic ALUMODE with Y=10 (W, Y, carryin ignored; carryout=0):
  - 0100/0111: ~(X^Z).
  - 0101/0110: X^Z.
  - 1100: X|Z.
  - 1101: X|~Z.
  - 1110: ~(X|Z).
  - 1111: ~X&Z.
- Any other ALUMODE/Y combination: result 0, carryout 0.
- PREG=0: p/carryout are combinational, latency 0; reset has no effect on outputs.
- PREG=1: p/carryout update on rising clock edge when ce_p=1, latency 1. reset=0 forces p=0 and carryout=0 next edge, with priority over ce_p. Reset value of both outputs is 0.
- Wrap-around: results are truncated modulo 2^48; no saturation.

Optional Feature:
- Macro DSP_MULT_EN.
- Defined: multiplier instantiated; X=01 yields M.
- Undefined: no multiplier logic; X=01 yields 0; all other behaviour unchanged.

Decomposition:
- Package dsp_pkg holds:
  - ALUMODE localparams (ADD, ZSUB, etc.).
  - X/Y/Z/W select enums.
  - 48-bit word typedef.
- One natural sub-module, dsp_alu48_core: combinational muxes plus ALU.
- Top level adds the multiplier and the P register.

Test Plan:
- AND, PREG=0: alumode=1100, opmode=000110011, {a,b}=48'h0000_FFFF_00F0, c=48'h0000_0F0F_0FF0 → p=48'h0000_0F0F_00F0, carryout=0.
- ADD with carry, PREG=0: alumode=0000, opmode=000110011, {a,b}=48'hFFFF_FFFF_FFFF, c=1, carryin=0 → p=0, carryout=1.
- SUB: alumode=0011, opmode=000110011, c=100, {a,b}=30 → p=70.
- MUL (DSP_MULT_EN defined): opmode=000000001, alumode=0000, a=−3, b=7 → p=48'hFFFF_FFFF_FFEB (−21); macro undefined → p=0.
- Accumulate, PREG=1: opmode=000100011 (Z=P), alumode=0000, {a,b}=5, ce_p=1 for 4 cycles after reset → p=5,10,15,20. ce_p=0 holds 20.
- Reset mid-accumulate: reset=0 for one edge with ce_p=1 → p=0, carryout=0. Accumulation restarts at 5 on the next edge after reset=1.
